inta_sequencer: RTL and testbench
=================================

# inta_sequencer

Interrupt-acknowledge sequencer for the 8259A control logic. Tracks the CPU's INTA pulse train, drives the `control_state` (ACK1/ACK2/ACK3) and the latched one-hot `acknowledge_interrupt` consumed by the cascade signal logic, and places the vector or CALL bytes on the internal data bus. It sits directly upstream of the cascade block, between the priority resolver and the data bus buffer.

## Interface
- No parameters.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `interrupt_acknowledge_n`  in  1  INTA pin, active-low, already synchronous to `clock`.
- `u8086_or_mcs80_config`  in  1  ICW4 µPM: 1 = 8086 (2 pulses), 0 = MCS-80/85 (3 pulses).
- `interrupt_request_one_hot`  in  8  highest-priority pending request from the priority resolver (0 or one-hot).
- `interrupt_vector_base`  in  5  ICW2 T7–T3.
- `call_address_low`, `call_address_high`  in  8 each  MCS-80 CALL address bytes from ICW decode.
- `cascade_output_ack_2_3`  in  1  from the cascade block; 1 = this device drives the ACK2/ACK3 data.
- `control_state`  out  3  CTL_READY=000, ACK1=001, ACK2=010, ACK3=011.
- `acknowledge_interrupt`  out  8  one-hot level latched at ACK1 entry.
- `latch_in_service`  out  1  one-cycle pulse at ACK1 entry (sets ISR).
- `end_of_acknowledge_sequence`  out  1  one-cycle pulse when the last INTA deasserts.
- `auto_eoi_clear`  out  1  one-cycle pulse coincident with end of sequence (see Configuration).
- `data_out`  out  8  byte to the data bus buffer.
- `data_out_enable`  out  1  1 = drive `data_out`.

## Operation
- Edge detect: register `interrupt_acknowledge_n`; fall = prev 1, now 0; rise = prev 0, now 1.
- FSM: CTL_READY –fall→ ACK1. ACK1 –fall→ ACK2. ACK2 –fall→ ACK3 only if MCS-80. Final state is ACK2 (8086) or ACK3 (MCS-80); a rise in the final state → CTL_READY and pulses `end_of_acknowledge_sequence`.
- Rises in non-final states: no state change. Falls in the final state: ignored.
- ACK1 entry: `acknowledge_interrupt` ← `interrupt_request_one_hot`; if that is 0 (spurious), load 8'h80 (IR7). Pulse `latch_in_service`. The value is held until return to CTL_READY, then cleared to 0.
- Level = binary index of `acknowledge_interrupt` (3 bits).
- 8086 data: ACK1 not driven; ACK2 drives {`interrupt_vector_base`, level} if `cascade_output_ack_2_3`.
- MCS-80 data: ACK1 drives 8'hCD (CALL) unconditionally for a master; ACK2 drives `call_address_low`, ACK3 drives `call_address_high`, each only if `cascade_output_ack_2_3`.
- `data_out_enable` = 1 only while `interrupt_acknowledge_n` = 0 in a driving state; `data_out` = 0 when not enabled.

## Timing
- Reset values: `control_state` = CTL_READY, `acknowledge_interrupt` = 0, all pulses 0, `data_out` = 0, `data_out_enable` = 0, edge register = 1.
- State, `acknowledge_interrupt` and `latch_in_service` update on the clock edge after the fall is detected: 1-cycle latency from the sampled INTA low.
- `data_out`/`data_out_enable` are registered and valid one cycle after state entry. They drop on the cycle after the INTA rise.
- Reset mid-sequence: immediate return to CTL_READY with no end pulse. A following INTA fall starts a fresh ACK1.
- Change of `u8086_or_mcs80_config` mid-sequence: sampled at each fall, so the count follows the current value.

## Configuration
- `INTA_AUTO_EOI_EN` defined: `auto_eoi_clear` pulses in the same cycle as `end_of_acknowledge_sequence`, and the ISR bit is cleared for the latched level.
- Not defined: `auto_eoi_clear` is tied to 0 and its logic is not compiled.

## Structure
- Shared package `pic8259_pkg`:
  - the control-state encodings CTL_READY/ACK1/ACK2/ACK3, shared with the cascade block;
  - the CALL opcode constant 8'hCD;
  - the one-hot-to-binary function (bit2num).
- One sub-module, `inta_edge_detect`, provides the registered fall/rise pulses.

## Test plan
- 8086 mode, request 8'h08, base 5'h10; two INTA pulses → states 001, 010, 000; ACK2 `data_out` = 8'h83; one end pulse.
- MCS-80 mode, request 8'h01, low = 8'h40, high = 8'h12; three pulses → data bytes 8'hCD, 8'h40, 8'h12.
- Spurious: request 0 at the first fall → `acknowledge_interrupt` = 8'h80; 8086 vector low bits = 3'b111.
- `cascade_output_ack_2_3` = 0 in ACK2 → `data_out_enable` stays 0, state still advances.
- Reset asserted in ACK2 → all outputs at reset values next cycle; no `end_of_acknowledge_sequence` pulse.
- With `INTA_AUTO_EOI_EN`, 8086 sequence → `auto_eoi_clear` pulses with the end pulse. Without it, `auto_eoi_clear` stays 0.

Source files
------------

// File: rtl/pic8259_pkg.sv
// Shared 8259A definitions.
// - ctl_state_e : control-state encodings seen by the cascade block
// - CALL_OPCODE : MCS-80/85 CALL opcode driven on the first INTA
// - bit2num     : one-hot to binary index
package pic8259_pkg;

  typedef enum logic [2:0] {
    CTL_READY = 3'b000,
    ACK1      = 3'b001,
    ACK2      = 3'b010,
    ACK3      = 3'b011
  } ctl_state_e;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  // Index of the set bit; 0 for a zero input.
  function automatic logic [2:0] bit2num(input logic [7:0] one_hot);
    logic [2:0] num;
    num = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (one_hot[i]) num = num | i[2:0];
    end
    return num;
  endfunction

endpackage

// File: rtl/inta_edge_detect.sv
// Registered edge detector for the INTA pin.
// Ports:
//   clock_i  - system clock
//   reset_i  - asynchronous active-high reset
//   inta_n_i - INTA pin (active-low, synchronous to clock_i)
//   fall_o   - one-cycle pulse, registered, after a 1->0 transition
//   rise_o   - one-cycle pulse, registered, after a 0->1 transition
module inta_edge_detect (
  input  logic clock_i,
  input  logic reset_i,
  input  logic inta_n_i,
  output logic fall_o,
  output logic rise_o
);

  logic inta_n_q;
  logic fall_q;
  logic rise_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      inta_n_q <= 1'b1;
      fall_q   <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      inta_n_q <= inta_n_i;
      fall_q   <= inta_n_q & ~inta_n_i;
      rise_q   <= ~inta_n_q & inta_n_i;
    end
  end

  assign fall_o = fall_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer for the 8259A control logic.
// Follows the INTA pulse train, latches the acknowledged request and
// drives the vector / CALL bytes toward the data bus buffer.
// Optional feature macro: INTA_AUTO_EOI_EN (auto_eoi_clear pulse at end
// of sequence); when undefined auto_eoi_clear is tied low.
// Ports:
//   clock, reset                 - clock, async active-high reset
//   interrupt_acknowledge_n      - INTA pin, active-low, synchronous
//   u8086_or_mcs80_config        - 1 = 8086 (2 pulses), 0 = MCS-80/85 (3)
//   interrupt_request_one_hot    - highest-priority pending request
//   interrupt_vector_base        - ICW2 T7..T3
//   call_address_low/high        - MCS-80 CALL address bytes
//   cascade_output_ack_2_3       - this device drives ACK2/ACK3 data
//   control_state                - CTL_READY/ACK1/ACK2/ACK3
//   acknowledge_interrupt        - one-hot level latched at ACK1 entry
//   latch_in_service             - pulse at ACK1 entry
//   end_of_acknowledge_sequence  - pulse when the last INTA deasserts
//   auto_eoi_clear               - pulse with end of sequence (optional)
//   data_out, data_out_enable    - registered byte and its enable
module inta_sequencer
  import pic8259_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       interrupt_acknowledge_n,
  input  logic       u8086_or_mcs80_config,
  input  logic [7:0] interrupt_request_one_hot,
  input  logic [4:0] interrupt_vector_base,
  input  logic [7:0] call_address_low,
  input  logic [7:0] call_address_high,
  input  logic       cascade_output_ack_2_3,
  output logic [2:0] control_state,
  output logic [7:0] acknowledge_interrupt,
  output logic       latch_in_service,
  output logic       end_of_acknowledge_sequence,
  output logic       auto_eoi_clear,
  output logic [7:0] data_out,
  output logic       data_out_enable
);

  logic       fall;
  logic       rise;
  logic       final_state;
  logic [2:0] level;

  ctl_state_e state_q, state_d;
  logic [7:0] ack_q, ack_d;
  logic       lis_q, lis_d;
  logic       eos_q, eos_d;
  logic [7:0] dout_q, dout_d;
  logic       doe_q, doe_d;

  inta_edge_detect u_edge (
    .clock_i  (clock),
    .reset_i  (reset),
    .inta_n_i (interrupt_acknowledge_n),
    .fall_o   (fall),
    .rise_o   (rise)
  );

  assign level = bit2num(ack_q);

  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    lis_d       = 1'b0;
    eos_d       = 1'b0;
    final_state = (state_q == ACK3) ||
                  ((state_q == ACK2) && u8086_or_mcs80_config);

    case (state_q)
      CTL_READY: if (fall) begin
        state_d = ACK1;
        // A request that vanished before INTA is acknowledged as IR7.
        ack_d   = (interrupt_request_one_hot == '0) ? 8'h80
                                                    : interrupt_request_one_hot;
        lis_d   = 1'b1;
      end
      ACK1: if (fall) state_d = ACK2;
      ACK2: if (fall && !u8086_or_mcs80_config) state_d = ACK3;
      default: ;
    endcase

    if (rise && final_state) begin
      state_d = CTL_READY;
      ack_d   = '0;
      eos_d   = 1'b1;
    end
  end

  // Data byte follows the registered state, so it lags state entry by one cycle.
  always_comb begin
    dout_d = '0;
    doe_d  = 1'b0;
    if (!interrupt_acknowledge_n) begin
      case (state_q)
        ACK1: if (!u8086_or_mcs80_config) begin
          doe_d  = 1'b1;
          dout_d = CALL_OPCODE;
        end
        ACK2: if (cascade_output_ack_2_3) begin
          doe_d  = 1'b1;
          dout_d = u8086_or_mcs80_config ? {interrupt_vector_base, level}
                                         : call_address_low;
        end
        ACK3: if (cascade_output_ack_2_3) begin
          doe_d  = 1'b1;
          dout_d = call_address_high;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= CTL_READY;
      ack_q   <= '0;
      lis_q   <= 1'b0;
      eos_q   <= 1'b0;
      dout_q  <= '0;
      doe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      lis_q   <= lis_d;
      eos_q   <= eos_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
    end
  end

`ifdef INTA_AUTO_EOI_EN
  logic aeoi_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) aeoi_q <= 1'b0;
    else       aeoi_q <= eos_d;
  end

  assign auto_eoi_clear = aeoi_q;
`else
  assign auto_eoi_clear = 1'b0;
`endif

  assign control_state               = state_q;
  assign acknowledge_interrupt       = ack_q;
  assign latch_in_service            = lis_q;
  assign end_of_acknowledge_sequence = eos_q;
  assign data_out                    = dout_q;
  assign data_out_enable             = doe_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Self-checking bench for inta_sequencer: directed scenarios plus
// randomized INTA pulse trains compared every cycle with a pulse-count model.
module tb_inta_sequencer;

`ifdef INTA_AUTO_EOI_EN
  localparam bit AEOI = 1'b1;
`else
  localparam bit AEOI = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       inta_n;
  logic       u8086;
  logic [7:0] req;
  logic [4:0] base;
  logic [7:0] call_lo;
  logic [7:0] call_hi;
  logic       casc;
  logic [2:0] control_state;
  logic [7:0] acknowledge_interrupt;
  logic       latch_in_service;
  logic       end_of_acknowledge_sequence;
  logic       auto_eoi_clear;
  logic [7:0] data_out;
  logic       data_out_enable;

  always #5 clk = ~clk;

  inta_sequencer dut (
    .clock                       (clk),
    .reset                       (reset),
    .interrupt_acknowledge_n     (inta_n),
    .u8086_or_mcs80_config       (u8086),
    .interrupt_request_one_hot   (req),
    .interrupt_vector_base       (base),
    .call_address_low            (call_lo),
    .call_address_high           (call_hi),
    .cascade_output_ack_2_3      (casc),
    .control_state               (control_state),
    .acknowledge_interrupt       (acknowledge_interrupt),
    .latch_in_service            (latch_in_service),
    .end_of_acknowledge_sequence (end_of_acknowledge_sequence),
    .auto_eoi_clear              (auto_eoi_clear),
    .data_out                    (data_out),
    .data_out_enable             (data_out_enable)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Model: pin history, delayed edge events, and number of accepted falls.
  logic       m_prev_n;
  logic       m_fall, m_rise;
  int         m_count;
  logic [7:0] m_ack;
  logic [2:0] e_state;
  logic [7:0] e_ack, e_dout;
  logic       e_lis, e_eos, e_aeoi, e_doe;

  // Observations gathered by the compare routine.
  int         eos_seen, aeoi_seen, doe_cycles;
  logic [7:0] bytes_seen[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_prev_n = 1'b1; m_fall = 1'b0; m_rise = 1'b0; m_count = 0; m_ack = '0;
    e_state = '0; e_ack = '0; e_dout = '0; e_lis = 1'b0; e_eos = 1'b0;
    e_aeoi = 1'b0; e_doe = 1'b0;
  endtask

  // Expected outputs after the next rising edge, from inputs held now.
  task automatic model_step();
    logic [7:0] nd;
    logic       ne;
    logic [2:0] lvl;
    logic       last;
    if (reset) begin
      model_reset();
      return;
    end
    nd = '0; ne = 1'b0; lvl = '0;
    for (int i = 0; i < 8; i++) if (m_ack == (8'd1 << i)) lvl = i[2:0];
    if (!inta_n) begin
      if (m_count == 1 && !u8086) begin ne = 1'b1; nd = 8'hCD; end
      else if (m_count == 2 && casc) begin
        ne = 1'b1;
        nd = u8086 ? {base, lvl} : call_lo;
      end else if (m_count == 3 && casc) begin ne = 1'b1; nd = call_hi; end
    end
    e_lis = 1'b0; e_eos = 1'b0;
    last = (m_count == 3) || (m_count == 2 && u8086);
    if (m_fall) begin
      if (m_count == 0) begin
        m_count = 1; m_ack = (req == 8'd0) ? 8'h80 : req; e_lis = 1'b1;
      end else if (m_count == 1) m_count = 2;
      else if (m_count == 2 && !u8086) m_count = 3;
    end else if (m_rise && last) begin
      m_count = 0; m_ack = '0; e_eos = 1'b1;
    end
    m_fall   = m_prev_n & ~inta_n;
    m_rise   = ~m_prev_n & inta_n;
    m_prev_n = inta_n;
    e_state  = m_count[2:0];
    e_ack    = m_ack;
    e_dout   = nd;
    e_doe    = ne;
    e_aeoi   = AEOI ? e_eos : 1'b0;
  endtask

  task automatic compare();
    chk("control_state", {5'd0, control_state}, {5'd0, e_state});
    chk("acknowledge_interrupt", acknowledge_interrupt, e_ack);
    chk("latch_in_service", {7'd0, latch_in_service}, {7'd0, e_lis});
    chk("end_of_sequence", {7'd0, end_of_acknowledge_sequence}, {7'd0, e_eos});
    chk("auto_eoi_clear", {7'd0, auto_eoi_clear}, {7'd0, e_aeoi});
    chk("data_out", data_out, e_dout);
    chk("data_out_enable", {7'd0, data_out_enable}, {7'd0, e_doe});
    if (end_of_acknowledge_sequence) eos_seen++;
    if (auto_eoi_clear) aeoi_seen++;
    if (data_out_enable) begin
      doe_cycles++;
      if (bytes_seen.size() == 0 || bytes_seen[$] != data_out) bytes_seen.push_back(data_out);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic pulse(input int lo, input int hi);
    inta_n = 1'b0;
    repeat (lo) tick();
    inta_n = 1'b1;
    repeat (hi) tick();
  endtask

  task automatic clear_obs();
    eos_seen = 0; aeoi_seen = 0; doe_cycles = 0;
    bytes_seen.delete();
  endtask

  initial begin
    reset = 1'b1; inta_n = 1'b1; u8086 = 1'b1; req = '0; base = '0;
    call_lo = '0; call_hi = '0; casc = 1'b1;
    model_reset();
    clear_obs();
    @(negedge clk);
    tick(); tick();
    chk("reset_state", {5'd0, control_state}, 8'h00);
    chk("reset_dout_en", {7'd0, data_out_enable}, 8'h00);
    reset = 1'b0;
    tick();

    // 8086, IR3, base 5'h10: vector 8'h83 on ACK2.
    u8086 = 1'b1; req = 8'h08; base = 5'h10; casc = 1'b1;
    clear_obs();
    pulse(5, 3);
    chk("8086_after_p1_state", {5'd0, control_state}, 8'h01);
    chk("8086_latched", acknowledge_interrupt, 8'h08);
    inta_n = 1'b0;
    repeat (5) tick();
    chk("8086_ack2_state", {5'd0, control_state}, 8'h02);
    chk("8086_vector", data_out, 8'h83);
    inta_n = 1'b1;
    repeat (3) tick();
    chk("8086_end_state", {5'd0, control_state}, 8'h00);
    chk("8086_eos_count", eos_seen[7:0], 8'd1);
    chk("8086_aeoi_count", aeoi_seen[7:0], AEOI ? 8'd1 : 8'd0);
    chk("8086_ack_cleared", acknowledge_interrupt, 8'h00);

    // MCS-80: CALL, low, high bytes.
    u8086 = 1'b0; req = 8'h01; call_lo = 8'h40; call_hi = 8'h12;
    clear_obs();
    pulse(5, 3); pulse(5, 3); pulse(5, 3);
    chk("mcs_byte_count", bytes_seen.size() == 3 ? 8'd3 : 8'd0, 8'd3);
    if (bytes_seen.size() == 3) begin
      chk("mcs_byte0", bytes_seen[0], 8'hCD);
      chk("mcs_byte1", bytes_seen[1], 8'h40);
      chk("mcs_byte2", bytes_seen[2], 8'h12);
    end
    chk("mcs_eos_count", eos_seen[7:0], 8'd1);

    // Spurious request: IR7 latched, vector low bits 3'b111.
    u8086 = 1'b1; req = 8'h00; base = 5'h10;
    clear_obs();
    pulse(5, 3);
    chk("spurious_latched", acknowledge_interrupt, 8'h80);
    inta_n = 1'b0;
    repeat (5) tick();
    chk("spurious_vector", data_out, 8'h87);
    inta_n = 1'b1;
    repeat (3) tick();

    // Not the driving device in ACK2: no data, sequence still completes.
    req = 8'h04; casc = 1'b0;
    clear_obs();
    pulse(5, 3); pulse(5, 3);
    chk("nocasc_doe_cycles", doe_cycles[7:0], 8'd0);
    chk("nocasc_eos_count", eos_seen[7:0], 8'd1);
    chk("nocasc_end_state", {5'd0, control_state}, 8'h00);
    casc = 1'b1;

    // Reset in ACK2: outputs return at once, no end pulse.
    req = 8'h20;
    clear_obs();
    pulse(5, 3);
    inta_n = 1'b0;
    repeat (4) tick();
    chk("rst_pre_state", {5'd0, control_state}, 8'h02);
    reset = 1'b1;
    #1;
    chk("rst_state", {5'd0, control_state}, 8'h00);
    chk("rst_ack", acknowledge_interrupt, 8'h00);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_doe", {7'd0, data_out_enable}, 8'h00);
    inta_n = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_no_eos", eos_seen[7:0], 8'd0);
    pulse(3, 2);
    chk("rst_fresh_ack1", {5'd0, control_state}, 8'h01);
    chk("rst_fresh_latch", acknowledge_interrupt, 8'h20);
    pulse(4, 3);

    // Randomized pulse trains with config / cascade / request changes.
    for (int n = 0; n < 400; n++) begin
      int r;
      if ($urandom_range(0, 3) == 0) u8086 = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 8);
      req     = (r == 8) ? 8'h00 : (8'd1 << r);
      base    = 5'($urandom());
      call_lo = 8'($urandom());
      call_hi = 8'($urandom());
      casc    = ($urandom_range(0, 4) != 0);
      pulse($urandom_range(1, 4), $urandom_range(1, 4));
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
    end
    inta_n = 1'b1;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
